// File: rtl/spi_reg_bridge_if.sv
// Signal bundle between spi_reg_bridge, the upstream spi_slave and the system register bus.
// The master modport is the bridge's view; slave is the environment's view.
interface spi_reg_bridge_if #(
  parameter int unsigned Nbit = 8
);
  logic            ss_n;
  logic [Nbit-1:0] rx_data;
  logic            rx_strobe;
  logic [Nbit-1:0] tx_data;
  logic            tx_strobe;
  logic            wr_en;
  logic [Nbit-2:0] wr_addr;
  logic [Nbit-1:0] wr_data;
  logic [Nbit-2:0] rd_addr;
  logic [Nbit-1:0] rd_data;
  logic            rd_en;
  logic            busy;

  modport master (
    input  ss_n, rx_data, rx_strobe, tx_strobe, rd_data,
    output tx_data, wr_en, wr_addr, wr_data, rd_addr, rd_en, busy
  );

  modport slave (
    output ss_n, rx_data, rx_strobe, tx_strobe, rd_data,
    input  tx_data, wr_en, wr_addr, wr_data, rd_addr, rd_en, busy
  );
endinterface

// File: rtl/spi_reg_bridge.sv
// SPI word stream to register bus bridge: decodes cmd/addr/data frames with address
// auto-increment and returns status or read data to the SPI master.
module spi_reg_bridge #(
  parameter int unsigned    Nbit       = 8,
  parameter logic [Nbit-1:0] StatusByte = 8'hA5
) (
  input logic                clk,
  input logic                rst_n,
  spi_reg_bridge_if.master   bus
);

  localparam int unsigned AddrW = Nbit - 1;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StWrData,
    StRdTurn,
    StRdData
  } state_e;

  state_e          state_q;
  logic            ss_meta_q;
  logic            ss_sync_q;
  logic [AddrW-1:0] addr_q;
  logic [Nbit-1:0] tx_data_q;
  logic            wr_en_q;
  logic [AddrW-1:0] wr_addr_q;
  logic [Nbit-1:0] wr_data_q;
  logic            rd_en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ss_meta_q <= 1'b1;
      ss_sync_q <= 1'b1;
      addr_q    <= '0;
      tx_data_q <= StatusByte;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_en_q   <= 1'b0;
    end else begin
      ss_meta_q <= bus.ss_n;
      ss_sync_q <= ss_meta_q;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;

      // Read address advances one cycle after rd_en so rd_addr still names the consumed word.
      if (rd_en_q) begin
        addr_q <= addr_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          tx_data_q <= StatusByte;
          if (!ss_sync_q) begin
            state_q <= StCmd;
          end
        end
        StCmd: begin
          tx_data_q <= StatusByte;
          if (bus.rx_strobe) begin
            addr_q  <= bus.rx_data[AddrW-1:0];
            state_q <= bus.rx_data[Nbit-1] ? StWrData : StRdTurn;
          end
        end
        StWrData: begin
          tx_data_q <= StatusByte;
          if (bus.rx_strobe) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_q;
            wr_data_q <= bus.rx_data;
            addr_q    <= addr_q + 1'b1;
          end
        end
        StRdTurn: begin
          tx_data_q <= bus.rd_data;
          if (bus.rx_strobe) begin
            state_q <= StRdData;
          end
        end
        StRdData: begin
          tx_data_q <= bus.rd_data;
          if (bus.tx_strobe) begin
            rd_en_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase

      // Abort wins over the state transition, but the word above is still processed.
      if (ss_sync_q) begin
        state_q <= StIdle;
      end
    end
  end

  assign bus.tx_data = tx_data_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.rd_addr = addr_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.busy    = (state_q != StIdle);

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: models spi_slave word timing and a system register file,
// and checks every SPI word and bus pulse against a register-array reference model.
module tb_spi_reg_bridge;

  localparam int unsigned Nbit   = 8;
  localparam logic [7:0]  Status = 8'hA5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b1;

  always #5 clk = ~clk;

  spi_reg_bridge_if #(.Nbit(Nbit)) bus ();

  spi_reg_bridge #(
    .Nbit      (Nbit),
    .StatusByte(Status)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [7:0] sys_regs [128];
  logic [7:0] model    [128];
  int vecs = 0;
  int errs = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int both_cnt = 0;
  logic [7:0] fixed_q[$];

  // System register file: written by the DUT bus, read combinationally.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 128; i++) sys_regs[i] <= 8'h00;
    end else if (bus.wr_en) begin
      sys_regs[bus.wr_addr] <= bus.wr_data;
    end
  end
  assign bus.rd_data = sys_regs[bus.rd_addr];

  always @(negedge clk) begin
    if (bus.wr_en) wr_cnt++;
    if (bus.rd_en) rd_cnt++;
    if (bus.wr_en && bus.rd_en) both_cnt++;
  end

  // One SPI word as spi_slave presents it: tx_strobe, then rx_strobe three cycles later.
  task automatic xfer_word(input logic [7:0] mosi, output logic [7:0] miso,
                           output logic rd_seen, output logic [6:0] ra,
                           output logic wr_seen, output logic [6:0] wa, output logic [7:0] wd);
    @(posedge clk); #1 bus.tx_strobe = 1'b1;
    @(negedge clk); miso = bus.tx_data;
    @(posedge clk); #1 bus.tx_strobe = 1'b0;
    @(negedge clk); rd_seen = bus.rd_en; ra = bus.rd_addr;
    @(posedge clk);
    @(posedge clk); #1 bus.rx_data = mosi; bus.rx_strobe = 1'b1;
    @(posedge clk); #1 bus.rx_strobe = 1'b0;
    @(negedge clk); wr_seen = bus.wr_en; wa = bus.wr_addr; wd = bus.wr_data;
  endtask

  task automatic run_frame(input logic wr, input logic [6:0] start, input int n);
    logic [6:0] a, ra, wa;
    logic [7:0] miso, d, wd;
    logic rs, ws;
    int wc0, rc0;
    wc0 = wr_cnt;
    rc0 = rd_cnt;
    a = start;
    @(posedge clk); #1 bus.ss_n = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    vecs++;
    if (bus.busy !== 1'b0) begin
      errs++; $display("FAIL busy_early: got %b want 0", bus.busy);
    end
    @(posedge clk); @(negedge clk);
    vecs++;
    if (bus.busy !== 1'b1) begin
      errs++; $display("FAIL busy_rise: got %b want 1", bus.busy);
    end
    xfer_word({wr, start}, miso, rs, ra, ws, wa, wd);
    vecs++;
    if ({miso, rs, ws} !== {Status, 2'b00}) begin
      errs++; $display("FAIL cmd_word: got miso=%h rd=%b wr=%b want %h 0 0", miso, rs, ws, Status);
    end
    if (!wr) begin
      xfer_word(8'($urandom), miso, rs, ra, ws, wa, wd);
      vecs++;
      if ({rs, ws} !== 2'b00) begin
        errs++; $display("FAIL turnaround: got rd=%b wr=%b want 0 0", rs, ws);
      end
    end
    for (int i = 0; i < n; i++) begin
      if (wr) begin
        if (fixed_q.size() > 0) d = fixed_q.pop_front();
        else d = 8'($urandom);
        xfer_word(d, miso, rs, ra, ws, wa, wd);
        vecs++;
        if ({miso, rs, ws, wa, wd} !== {Status, 1'b0, 1'b1, a, d}) begin
          errs++;
          $display("FAIL write_word: got miso=%h rd=%b wr=%b addr=%h data=%h want %h 0 1 %h %h",
                   miso, rs, ws, wa, wd, Status, a, d);
        end
        model[a] = d;
      end else begin
        xfer_word(8'($urandom), miso, rs, ra, ws, wa, wd);
        vecs++;
        if ({miso, rs, ra, ws} !== {model[a], 1'b1, a, 1'b0}) begin
          errs++;
          $display("FAIL read_word: got miso=%h rd=%b addr=%h wr=%b want %h 1 %h 0",
                   miso, rs, ra, ws, model[a], a);
        end
      end
      a = a + 7'd1;
    end
    @(posedge clk); #1 bus.ss_n = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    vecs++;
    if (bus.busy !== 1'b1) begin
      errs++; $display("FAIL busy_hold: got %b want 1", bus.busy);
    end
    @(posedge clk); @(negedge clk);
    vecs++;
    if (bus.busy !== 1'b0) begin
      errs++; $display("FAIL busy_fall: got %b want 0", bus.busy);
    end
    vecs++;
    if ((wr_cnt - wc0) != (wr ? n : 0) || (rd_cnt - rc0) != (wr ? 0 : n)) begin
      errs++;
      $display("FAIL pulse_count: got wr=%0d rd=%0d want wr=%0d rd=%0d",
               wr_cnt - wc0, rd_cnt - rc0, wr ? n : 0, wr ? 0 : n);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    vecs++;
    if ({bus.tx_data, bus.wr_en, bus.rd_en, bus.busy, bus.wr_addr, bus.wr_data, bus.rd_addr}
        !== {Status, 3'b000, 7'h00, 8'h00, 7'h00}) begin
      errs++;
      $display("FAIL %s: got tx=%h wr=%b rd=%b busy=%b wa=%h wd=%h ra=%h want %h 0 0 0 00 00 00",
               tag, bus.tx_data, bus.wr_en, bus.rd_en, bus.busy, bus.wr_addr, bus.wr_data,
               bus.rd_addr, Status);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_values");
    #1 rst_n = 1'b1;
    clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_write_burst();
    fixed_q = '{8'h11, 8'h22};
    run_frame(1'b1, 7'h05, 2);
  endtask

  task automatic test_read_burst();
    fixed_q = '{8'h3C, 8'hC3};
    run_frame(1'b1, 7'h03, 2);
    run_frame(1'b0, 7'h03, 2);
  endtask

  task automatic test_wrap();
    fixed_q = '{8'h5A, 8'h6B};
    run_frame(1'b1, 7'h7F, 2);
    run_frame(1'b0, 7'h7E, 3);
  endtask

  task automatic test_abort();
    logic [7:0] miso, wd;
    logic rs, ws;
    logic [6:0] ra, wa;
    int wc0;
    wc0 = wr_cnt;
    @(posedge clk); #1 bus.ss_n = 1'b0;
    repeat (3) @(posedge clk);
    xfer_word(8'h90, miso, rs, ra, ws, wa, wd);
    @(posedge clk); #1 bus.ss_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vecs++;
    if ({bus.busy, ws} !== 2'b00 || wr_cnt != wc0) begin
      errs++;
      $display("FAIL abort: got busy=%b writes=%0d want busy=0 writes=0", bus.busy, wr_cnt - wc0);
    end
    fixed_q = '{8'h77};
    run_frame(1'b1, 7'h10, 1);
    run_frame(1'b0, 7'h10, 1);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] miso, wd;
    logic rs, ws;
    logic [6:0] ra, wa;
    int wc0;
    wc0 = wr_cnt;
    @(posedge clk); #1 bus.ss_n = 1'b0;
    repeat (3) @(posedge clk);
    xfer_word(8'h85, miso, rs, ra, ws, wa, wd);
    @(posedge clk); #1 bus.tx_strobe = 1'b1;
    @(posedge clk); #1 bus.tx_strobe = 1'b0;
    @(posedge clk); #1 bus.rx_data = 8'hEE; bus.rx_strobe = 1'b1; rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid_frame");
    @(posedge clk); #1 bus.rx_strobe = 1'b0; bus.ss_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vecs++;
    if (wr_cnt != wc0) begin
      errs++; $display("FAIL reset_no_write: got %0d writes want 0", wr_cnt - wc0);
    end
    run_frame(1'b1, 7'h05, 2);
    run_frame(1'b0, 7'h04, 4);
  endtask

  task automatic test_random();
    for (int f = 0; f < 100; f++) begin
      run_frame(1'($urandom), 7'($urandom), int'($urandom_range(1, 4)));
    end
  endtask

  initial begin
    bus.ss_n = 1'b1;
    bus.rx_data = 8'h00;
    bus.rx_strobe = 1'b0;
    bus.tx_strobe = 1'b0;
    for (int i = 0; i < 128; i++) model[i] = 8'h00;
    test_reset();
    test_write_burst();
    test_read_burst();
    test_wrap();
    test_abort();
    test_reset_mid_frame();
    test_random();
    vecs++;
    if (both_cnt != 0) begin
      errs++; $display("FAIL wr_rd_overlap: got %0d cycles want 0", both_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
